mult4_issue_stage: RTL

//   Sequential issue stage directly upstream of the 4x4 Wallace multiplier.
//   - Accepts operand pairs over valid/ready and buffers them in a DEPTH-entry FIFO.
//   - Drives the FIFO head onto the multiplier operand inputs.
//   - Captures the combinational product into an output register with valid/ready and a sequence tag.

---
 rtl/mult4_issue_if.sv | 28 ++
 rtl/mult4_issue_stage.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mult4_issue_if.sv
// Handshake bundle between the operand source, the issue stage and the result sink.
// Ports: in_* operand channel, mul_* multiplier link, out_* result channel, err flag.
interface mult4_issue_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_a;
   logic [3:0]       in_b;
   logic [3:0]       mul_a;
   logic [3:0]       mul_b;
   logic [8:0]       mul_result;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_result;
   logic [TAG_W-1:0] out_tag;
   logic             err;

   modport slave (
      input  in_valid, in_a, in_b, mul_result, out_ready,
      output in_ready, mul_a, mul_b, out_valid, out_result, out_tag, err
   );

   modport master (
      output in_valid, in_a, in_b, mul_result, out_ready,
      input  in_ready, mul_a, mul_b, out_valid, out_result, out_tag, err
   );
endinterface

// File: rtl/mult4_issue_stage.sv
// Issue stage ahead of the 4x4 multiplier: operand FIFO, registered operands, result reg.
// Ports: clk, rst (async high), bus (slave). Optional macro MULT4_SELFCHECK_EN drives err.
module mult4_issue_stage #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input logic          clk,
   input logic          rst,
   mult4_issue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       mem_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ov_q, ov_d;
   logic [7:0]       res_q, res_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [TAG_W-1:0] seq_q, seq_d;
   logic [3:0]       ma_q, ma_d;
   logic [3:0]       mb_q, mb_d;
   logic [7:0]       head;
   logic             push;
   logic             pop;
   logic             unused_msb;

   assign unused_msb = bus.mul_result[8];
   assign bus.in_ready = (cnt_q < CW'(DEPTH));
   assign push = bus.in_valid & bus.in_ready;
   assign pop = (cnt_q != '0) & (~ov_q | bus.out_ready);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ov_d  = ov_q;
      res_d = res_q;
      tag_d = tag_q;
      seq_d = seq_q;
      if (push) begin
         mem_d[wr_q] = {bus.in_a, bus.in_b};
         wr_d = wr_q + 1'b1;
      end
      if (pop) begin
         res_d = bus.mul_result[7:0];
         tag_d = seq_q;
         ov_d  = 1'b1;
         rd_d  = rd_q + 1'b1;
         seq_d = seq_q + 1'b1;
      end else if (ov_q & bus.out_ready) begin
         ov_d = 1'b0;
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      // Operands are registered from the next head so the multiplier sees no glitches.
      head = mem_d[rd_d];
      ma_d = (cnt_d == '0) ? 4'd0 : head[7:4];
      mb_d = (cnt_d == '0) ? 4'd0 : head[3:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ov_q  <= 1'b0;
         res_q <= '0;
         tag_q <= '0;
         seq_q <= '0;
         ma_q  <= '0;
         mb_q  <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ov_q  <= ov_d;
         res_q <= res_d;
         tag_q <= tag_d;
         seq_q <= seq_d;
         ma_q  <= ma_d;
         mb_q  <= mb_d;
      end
   end

   assign bus.mul_a      = ma_q;
   assign bus.mul_b      = mb_q;
   assign bus.out_valid  = ov_q;
   assign bus.out_result = res_q;
   assign bus.out_tag    = tag_q;

`ifdef MULT4_SELFCHECK_EN
   logic err_q, err_d;
   logic [7:0] ref_prod;

   assign ref_prod = {4'd0, ma_q} * {4'd0, mb_q};

   always_comb begin
      err_d = err_q;
      if (pop && (bus.mul_result[7:0] != ref_prod)) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif
endmodule
